// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the target and controller: byte size, FSM states
// and the bus-event encoding produced by i2c_bus_sync.
package i2c_pkg;

    localparam int BITS_PER_BYTE = 8;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RACK,
        IGNORE
    } i2c_state_e;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_START,
        EV_STOP
    } i2c_event_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Pad synchroniser for SCL/SDA: 2-FF sync plus one history stage, giving
// registered levels, SCL edge strobes and START/STOP detection.
module i2c_bus_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] sclSync_q;
    logic [1:0] sdaSync_q;
    logic       sclHist_q;
    logic       sdaHist_q;

    // Reset to the idle-high bus level so leaving reset cannot fake a START.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclSync_q <= 2'b11;
            sdaSync_q <= 2'b11;
            sclHist_q <= 1'b1;
            sdaHist_q <= 1'b1;
        end else begin
            sclSync_q <= {sclSync_q[0], scl_in};
            sdaSync_q <= {sdaSync_q[0], sda_in};
            sclHist_q <= sclSync_q[1];
            sdaHist_q <= sdaSync_q[1];
        end
    end

    assign scl       = sclSync_q[1];
    assign sda       = sdaSync_q[1];
    assign scl_rise  = scl & ~sclHist_q;
    assign scl_fall  = ~scl & sclHist_q;
    assign start_det = scl & sclHist_q & sdaHist_q & ~sda;
    assign stop_det  = scl & sclHist_q & ~sdaHist_q & sda;

endmodule

// File: rtl/i2c_target.sv
// I2C target: register-mapped responder with pointer write, burst write and
// auto-incrementing burst read. Open-drain SDA via sda_oe, no clock stretching.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDR = 7'h68
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    localparam logic [3:0] LAST_BIT  = 4'(BITS_PER_BYTE - 1);
    localparam logic [3:0] FULL_BYTE = 4'(BITS_PER_BYTE);

    logic scl, sda, sclRise, sclFall, startDet, stopDet;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl       (scl),
        .sda       (sda),
        .scl_rise  (sclRise),
        .scl_fall  (sclFall),
        .start_det (startDet),
        .stop_det  (stopDet)
    );

    i2c_state_e state_q, state_d;
    i2c_event_e busEvent;
    logic [3:0] bitCnt_q, bitCnt_d;
    logic [7:0] rxShift_q, rxShift_d, txShift_q, txShift_d;
    logic [7:0] regAddr_q, regAddr_d, regWdata_q, regWdata_d;
    logic       sdaOe_q, sdaOe_d, regWe_q, regWe_d, regRe_q, regRe_d;
    logic       loadTx_q, loadTx_d, rw_q, rw_d, busy_q, busy_d;
    logic [7:0] byteIn;
    logic       byteDone;

    assign busEvent = startDet ? EV_START : (stopDet ? EV_STOP : EV_NONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bitCnt_q   <= '0;
            rxShift_q  <= '0;
            txShift_q  <= '0;
            regAddr_q  <= '0;
            regWdata_q <= '0;
            sdaOe_q    <= 1'b0;
            regWe_q    <= 1'b0;
            regRe_q    <= 1'b0;
            loadTx_q   <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            rxShift_q  <= rxShift_d;
            txShift_q  <= txShift_d;
            regAddr_q  <= regAddr_d;
            regWdata_q <= regWdata_d;
            sdaOe_q    <= sdaOe_d;
            regWe_q    <= regWe_d;
            regRe_q    <= regRe_d;
            loadTx_q   <= loadTx_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
        end
    end

    // In the ACK states sdaOe_q doubles as the phase flag: the first SCL fall
    // pulls SDA low, the second one ends the ACK bit.
    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        rxShift_d  = rxShift_q;
        txShift_d  = txShift_q;
        regAddr_d  = regAddr_q;
        regWdata_d = regWdata_q;
        sdaOe_d    = sdaOe_q;
        regWe_d    = 1'b0;
        regRe_d    = 1'b0;
        loadTx_d   = regRe_q;
        rw_d       = rw_q;
        busy_d     = busy_q;
        byteIn     = {rxShift_q[6:0], sda};
        byteDone   = sclRise && (bitCnt_q == LAST_BIT);

        if (regWe_q) begin
            regAddr_d = regAddr_q + 8'd1;
        end
        // Read data lands one clk after reg_re; on the first byte SCL is already
        // low, so the MSB goes straight out instead of waiting for a fall.
        if (loadTx_q) begin
            txShift_d = reg_rdata;
            if (state_q == RDATA && !scl) begin
                sdaOe_d   = ~reg_rdata[7];
                txShift_d = {reg_rdata[6:0], 1'b0};
            end
        end

        case (busEvent)
            EV_START: begin
                state_d  = ADDR;
                bitCnt_d = '0;
                sdaOe_d  = 1'b0;
                busy_d   = 1'b0;
            end
            EV_STOP: begin
                state_d = IDLE;
                sdaOe_d = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                case (state_q)
                    ADDR, PTR, WDATA: begin
                        if (sclRise) begin
                            rxShift_d = byteIn;
                            bitCnt_d  = bitCnt_q + 4'd1;
                        end
                        if (byteDone) begin
                            if (state_q == PTR) begin
                                regAddr_d = byteIn;
                                state_d   = PTR_ACK;
                            end else if (state_q == WDATA) begin
                                regWdata_d = byteIn;
                                regWe_d    = 1'b1;
                                state_d    = WDATA_ACK;
                            end else if (byteIn[7:1] == DEVICE_ADDR && byteIn[7:1] != 7'h00) begin
                                rw_d    = byteIn[0];
                                busy_d  = 1'b1;
                                state_d = ADDR_ACK;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                    ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                        if (sclFall) begin
                            sdaOe_d = ~sdaOe_q;
                            if (sdaOe_q) begin
                                bitCnt_d = '0;
                                if (state_q != ADDR_ACK) begin
                                    state_d = WDATA;
                                end else if (rw_q) begin
                                    regRe_d = 1'b1;
                                    state_d = RDATA;
                                end else begin
                                    state_d = PTR;
                                end
                            end
                        end
                    end
                    RDATA: begin
                        if (sclRise) begin
                            bitCnt_d = bitCnt_q + 4'd1;
                        end
                        if (sclFall) begin
                            if (bitCnt_q == FULL_BYTE) begin
                                sdaOe_d = 1'b0;
                                state_d = RACK;
                            end else begin
                                sdaOe_d   = ~txShift_q[7];
                                txShift_d = {txShift_q[6:0], 1'b0};
                            end
                        end
                    end
                    RACK: begin
                        if (sclRise) begin
                            regAddr_d = regAddr_q + 8'd1;
                            bitCnt_d  = '0;
                            if (!sda) begin
                                regRe_d = 1'b1;
                                state_d = RDATA;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = IGNORE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        endcase
    end

    assign sda_oe    = sdaOe_q;
    assign reg_addr  = regAddr_q;
    assign reg_wdata = regWdata_q;
    assign reg_we    = regWe_q;
    assign reg_re    = regRe_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Testbench for i2c_target: bit-banged I2C host, synchronous register file and a
// transaction-level memory/pointer model of the device.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       sclHost, sdaHost;
    logic       scl_in, sda_in;
    logic       sda_oe, reg_we, reg_re, busy;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;

    int testsRun = 0;
    int testsFailed = 0;

    logic [7:0] regMem [256];
    logic       memReady = 1'b0;
    logic [7:0] modelMem [256];
    logic [7:0] modelPtr;

    logic [7:0] weAddrQ[$];
    logic [7:0] weDataQ[$];
    int reCount = 0, bothHigh = 0, oeCycles = 0, busyCycles = 0;

    assign scl_in = sclHost;
    assign sda_in = sdaHost & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target #(.DEVICE_ADDR(7'h68)) dut (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    // Register file seen by the DUT: synchronous read, data valid the clk after reg_re.
    always @(posedge clk) begin
        if (!memReady) begin
            for (int i = 0; i < 256; i++) regMem[i] <= 8'(i) ^ 8'hA5;
            reg_rdata <= 8'h00;
            memReady  <= 1'b1;
        end else begin
            if (reg_we) regMem[reg_addr] <= reg_wdata;
            if (reg_re) reg_rdata <= regMem[reg_addr];
        end
    end

    always @(negedge clk) begin
        if (reg_we) begin
            weAddrQ.push_back(reg_addr);
            weDataQ.push_back(reg_wdata);
        end
        if (reg_re) reCount++;
        if (reg_we && reg_re) bothHigh++;
        if (sda_oe) oeCycles++;
        if (busy) busyCycles++;
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] simulation timeout");
    end

    task automatic quarter();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2cStart();
        sdaHost = 1'b1; quarter();
        sclHost = 1'b1; quarter();
        sdaHost = 1'b0; quarter();
        sclHost = 1'b0; quarter();
    endtask

    task automatic i2cStop();
        sdaHost = 1'b0; quarter();
        sclHost = 1'b1; quarter();
        sdaHost = 1'b1; quarter();
    endtask

    task automatic i2cBit(input logic b, output logic s);
        sdaHost = b; quarter();
        sclHost = 1'b1; quarter();
        s = sda_in; quarter();
        sclHost = 1'b0; quarter();
    endtask

    task automatic sendByte(input logic [7:0] d, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) i2cBit(d[i], s);
        i2cBit(1'b1, s);
        acked = ~s;
    endtask

    task automatic readByte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            i2cBit(1'b1, s);
            d[i] = s;
        end
        i2cBit(nack, s);
    endtask

    task automatic test_reset();
        reset = 1'b1; sclHost = 1'b1; sdaHost = 1'b1;
        repeat (4) @(negedge clk);
        testsRun++; if (sda_oe !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_sda_oe: got %b, want 0", sda_oe); end
        testsRun++; if (reg_addr !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_reg_addr: got %h, want 00", reg_addr); end
        testsRun++; if (reg_wdata !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_reg_wdata: got %h, want 00", reg_wdata); end
        testsRun++; if (reg_we !== 1'b0 || reg_re !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_strobes: got we=%b re=%b, want 0/0", reg_we, reg_re); end
        testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b, want 0", busy); end
        testsRun++; if (dut.state_q !== IDLE) begin testsFailed++; $display("[TB] FAIL reset_state: got %0d, want IDLE", dut.state_q); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        modelPtr = 8'h00;
    endtask

    task automatic test_write_basic();
        logic a0, a1, a2;
        int weBase;
        weBase = weAddrQ.size();
        i2cStart();
        sendByte(8'hD0, a0); sendByte(8'h6B, a1); sendByte(8'h00, a2);
        testsRun++; if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL wr_busy_before_stop: got %b, want 1", busy); end
        i2cStop(); quarter();
        modelPtr = 8'h6B; modelMem[modelPtr] = 8'h00; modelPtr++;
        testsRun++; if ({a0, a1, a2} !== 3'b111) begin testsFailed++; $display("[TB] FAIL wr_acks: got %b, want 111", {a0, a1, a2}); end
        testsRun++; if (weAddrQ.size() - weBase !== 1) begin testsFailed++; $display("[TB] FAIL wr_we_count: got %0d, want 1", weAddrQ.size() - weBase); end
        testsRun++; if (weAddrQ[weBase] !== 8'h6B || weDataQ[weBase] !== 8'h00) begin testsFailed++; $display("[TB] FAIL wr_we_payload: got %h/%h, want 6b/00", weAddrQ[weBase], weDataQ[weBase]); end
        testsRun++; if (reg_addr !== modelPtr) begin testsFailed++; $display("[TB] FAIL wr_reg_addr: got %h, want %h", reg_addr, modelPtr); end
        testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL wr_busy_after_stop: got %b, want 0", busy); end
    endtask

    task automatic test_foreign_addr();
        logic a0, a1;
        int weBase, reBase, oeBase, busyBase;
        weBase = weAddrQ.size(); reBase = reCount; oeBase = oeCycles; busyBase = busyCycles;
        i2cStart();
        sendByte(8'hA0, a0); sendByte(8'h55, a1);
        i2cStop(); quarter();
        testsRun++; if ({a0, a1} !== 2'b00) begin testsFailed++; $display("[TB] FAIL foreign_acks: got %b, want 00", {a0, a1}); end
        testsRun++; if (oeCycles - oeBase !== 0) begin testsFailed++; $display("[TB] FAIL foreign_sda_oe: got %0d driven cycles, want 0", oeCycles - oeBase); end
        testsRun++; if (weAddrQ.size() - weBase !== 0 || reCount - reBase !== 0) begin testsFailed++; $display("[TB] FAIL foreign_strobes: got we=%0d re=%0d, want 0/0", weAddrQ.size() - weBase, reCount - reBase); end
        testsRun++; if (busyCycles - busyBase !== 0) begin testsFailed++; $display("[TB] FAIL foreign_busy: got %0d busy cycles, want 0", busyCycles - busyBase); end
    endtask

    task automatic test_burst_read();
        logic a0, a1, a2;
        logic [7:0] b0, b1, b2;
        int reBase;
        reBase = reCount;
        i2cStart(); sendByte(8'hD0, a0); sendByte(8'h3B, a1);
        i2cStart(); sendByte(8'hD1, a2);
        readByte(1'b0, b0); readByte(1'b0, b1); readByte(1'b1, b2);
        testsRun++; if (sda_oe !== 1'b0) begin testsFailed++; $display("[TB] FAIL rd_release_after_nack: got %b, want 0", sda_oe); end
        testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rd_busy_after_nack: got %b, want 0", busy); end
        i2cStop(); quarter();
        modelPtr = 8'h3E;
        testsRun++; if ({a0, a1, a2} !== 3'b111) begin testsFailed++; $display("[TB] FAIL rd_acks: got %b, want 111", {a0, a1, a2}); end
        testsRun++; if ({b0, b1, b2} !== 24'h9E9998) begin testsFailed++; $display("[TB] FAIL rd_bytes: got %h %h %h, want 9e 99 98", b0, b1, b2); end
        testsRun++; if (reCount - reBase !== 3) begin testsFailed++; $display("[TB] FAIL rd_re_count: got %0d, want 3", reCount - reBase); end
        testsRun++; if (reg_addr !== 8'h3E) begin testsFailed++; $display("[TB] FAIL rd_reg_addr: got %h, want 3e", reg_addr); end
    endtask

    task automatic test_pointer_wrap();
        logic a0, a1, a2, a3;
        int weBase;
        weBase = weAddrQ.size();
        i2cStart();
        sendByte(8'hD0, a0); sendByte(8'hFF, a1); sendByte(8'h11, a2); sendByte(8'h22, a3);
        i2cStop(); quarter();
        modelPtr = 8'hFF;
        modelMem[modelPtr] = 8'h11; modelPtr++;
        modelMem[modelPtr] = 8'h22; modelPtr++;
        testsRun++; if ({a0, a1, a2, a3} !== 4'b1111) begin testsFailed++; $display("[TB] FAIL wrap_acks: got %b, want 1111", {a0, a1, a2, a3}); end
        testsRun++; if (weAddrQ.size() - weBase !== 2) begin testsFailed++; $display("[TB] FAIL wrap_we_count: got %0d, want 2", weAddrQ.size() - weBase); end
        testsRun++; if (weAddrQ[weBase] !== 8'hFF || weDataQ[weBase] !== 8'h11) begin testsFailed++; $display("[TB] FAIL wrap_we0: got %h/%h, want ff/11", weAddrQ[weBase], weDataQ[weBase]); end
        testsRun++; if (weAddrQ[weBase + 1] !== 8'h00 || weDataQ[weBase + 1] !== 8'h22) begin testsFailed++; $display("[TB] FAIL wrap_we1: got %h/%h, want 00/22", weAddrQ[weBase + 1], weDataQ[weBase + 1]); end
        testsRun++; if (reg_addr !== 8'h01) begin testsFailed++; $display("[TB] FAIL wrap_reg_addr: got %h, want 01", reg_addr); end
    endtask

    task automatic test_stop_abort();
        logic a0, a1, s;
        logic b0, b1, b2;
        int weBase;
        weBase = weAddrQ.size();
        i2cStart(); sendByte(8'hD0, a0); sendByte(8'h30, a1);
        i2cBit(1'b1, s); i2cBit(1'b0, s); i2cBit(1'b1, s); i2cBit(1'b0, s);
        i2cStop(); quarter();
        testsRun++; if ({a0, a1} !== 2'b11) begin testsFailed++; $display("[TB] FAIL abort_hdr_acks: got %b, want 11", {a0, a1}); end
        testsRun++; if (weAddrQ.size() - weBase !== 0) begin testsFailed++; $display("[TB] FAIL abort_no_we: got %0d, want 0", weAddrQ.size() - weBase); end
        testsRun++; if (dut.state_q !== IDLE) begin testsFailed++; $display("[TB] FAIL abort_state: got %0d, want IDLE", dut.state_q); end
        testsRun++; if (sda_oe !== 1'b0 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_released: got oe=%b busy=%b, want 0/0", sda_oe, busy); end
        i2cStart(); sendByte(8'hD0, b0); sendByte(8'h31, b1); sendByte(8'h5A, b2);
        i2cStop(); quarter();
        modelPtr = 8'h31; modelMem[modelPtr] = 8'h5A; modelPtr++;
        testsRun++; if ({b0, b1, b2} !== 3'b111) begin testsFailed++; $display("[TB] FAIL abort_next_acks: got %b, want 111", {b0, b1, b2}); end
        testsRun++; if (weAddrQ.size() - weBase !== 1 || weAddrQ[weBase] !== 8'h31 || weDataQ[weBase] !== 8'h5A) begin testsFailed++; $display("[TB] FAIL abort_next_we: got n=%0d %h/%h, want 1 31/5a", weAddrQ.size() - weBase, weAddrQ[weBase], weDataQ[weBase]); end
    endtask

    task automatic test_reset_during_read();
        logic a0, a1, a2, a3, s;
        logic [7:0] d, exp;
        i2cStart(); sendByte(8'hD0, a0); sendByte(8'h12, a1);
        i2cStart(); sendByte(8'hD1, a2);
        i2cBit(1'b1, s);
        testsRun++; if (sda_oe !== 1'b1) begin testsFailed++; $display("[TB] FAIL rst_rd_driving0: got %b, want 1", sda_oe); end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        testsRun++; if (sda_oe !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_rd_sda_oe: got %b, want 0", sda_oe); end
        testsRun++; if (reg_addr !== 8'h00 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_rd_regs: got addr=%h busy=%b, want 00/0", reg_addr, busy); end
        @(negedge clk); reset = 1'b0;
        sclHost = 1'b1; sdaHost = 1'b1;
        quarter(); quarter();
        modelPtr = 8'h00;
        i2cStart(); sendByte(8'hD1, a3);
        readByte(1'b1, d);
        i2cStop(); quarter();
        exp = modelMem[modelPtr]; modelPtr++;
        testsRun++; if ({a0, a1, a2, a3} !== 4'b1111) begin testsFailed++; $display("[TB] FAIL rst_rd_acks: got %b, want 1111", {a0, a1, a2, a3}); end
        testsRun++; if (d !== exp) begin testsFailed++; $display("[TB] FAIL rst_rd_data: got %h, want %h", d, exp); end
    endtask

    task automatic test_random();
        logic [7:0] ptr, rptr, d, exp;
        logic a;
        int n, m, weBase, reBase;
        logic [7:0] expWA[$];
        logic [7:0] expWD[$];
        for (int it = 0; it < 5; it++) begin
            ptr = 8'($urandom); n = int'($urandom_range(1, 3));
            weBase = weAddrQ.size();
            expWA.delete(); expWD.delete();
            i2cStart();
            sendByte(8'hD0, a);
            testsRun++; if (a !== 1'b1) begin testsFailed++; $display("[TB] FAIL rnd_wr_addr_ack: got %b, want 1", a); end
            sendByte(ptr, a);
            testsRun++; if (a !== 1'b1) begin testsFailed++; $display("[TB] FAIL rnd_ptr_ack: got %b, want 1", a); end
            modelPtr = ptr;
            for (int k = 0; k < n; k++) begin
                d = 8'($urandom);
                sendByte(d, a);
                testsRun++; if (a !== 1'b1) begin testsFailed++; $display("[TB] FAIL rnd_data_ack: got %b, want 1", a); end
                expWA.push_back(modelPtr); expWD.push_back(d);
                modelMem[modelPtr] = d; modelPtr++;
            end
            i2cStop(); quarter();
            testsRun++; if (weAddrQ.size() - weBase !== n) begin testsFailed++; $display("[TB] FAIL rnd_we_count: got %0d, want %0d", weAddrQ.size() - weBase, n); end
            for (int k = 0; k < n; k++) begin
                testsRun++; if (weAddrQ[weBase + k] !== expWA[k] || weDataQ[weBase + k] !== expWD[k]) begin testsFailed++; $display("[TB] FAIL rnd_we_payload: got %h/%h, want %h/%h", weAddrQ[weBase + k], weDataQ[weBase + k], expWA[k], expWD[k]); end
            end

            rptr = ($urandom_range(0, 1) == 1) ? ptr : 8'($urandom);
            m = int'($urandom_range(1, 3));
            reBase = reCount;
            i2cStart(); sendByte(8'hD0, a); sendByte(rptr, a);
            i2cStart(); sendByte(8'hD1, a);
            testsRun++; if (a !== 1'b1) begin testsFailed++; $display("[TB] FAIL rnd_rd_addr_ack: got %b, want 1", a); end
            modelPtr = rptr;
            for (int k = 0; k < m; k++) begin
                readByte(k == m - 1, d);
                exp = modelMem[modelPtr]; modelPtr++;
                testsRun++; if (d !== exp) begin testsFailed++; $display("[TB] FAIL rnd_rd_data: got %h, want %h", d, exp); end
            end
            testsRun++; if (sda_oe !== 1'b0) begin testsFailed++; $display("[TB] FAIL rnd_rd_release: got %b, want 0", sda_oe); end
            i2cStop(); quarter();
            testsRun++; if (reg_addr !== modelPtr) begin testsFailed++; $display("[TB] FAIL rnd_rd_reg_addr: got %h, want %h", reg_addr, modelPtr); end
            testsRun++; if (reCount - reBase !== m) begin testsFailed++; $display("[TB] FAIL rnd_re_count: got %0d, want %0d", reCount - reBase, m); end
        end
    endtask

    task automatic test_pulse_rules();
        testsRun++; if (bothHigh !== 0) begin testsFailed++; $display("[TB] FAIL pulse_we_re_overlap: got %0d cycles, want 0", bothHigh); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) modelMem[i] = 8'(i) ^ 8'hA5;
        test_reset();
        test_write_basic();
        test_foreign_addr();
        test_burst_read();
        test_pointer_wrap();
        test_stop_abort();
        test_reset_during_read();
        test_random();
        test_pulse_rules();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) responder: the other end of the bus from the team's i2c_controller.
- Lets the FPGA act as a register-mapped I2C device. Useful as a loopback/bench partner for the controller, and for exposing status registers to an external host.
- Implements MPU-style access: 7-bit address match, register pointer write, burst write, and burst read with auto-increment.
- No clock stretching; SDA is driven open-drain through an output-enable.

Parameters:
- DEVICE_ADDR, 7'h68: 7-bit bus address this target answers to.

Ports:
- clk  in  1  system clock; must be at least 16x the SCL frequency.
- reset  in  1  synchronous, active-high reset.
- scl_in  in  1  raw SCL from the pad (asynchronous).
- sda_in  in  1  raw SDA from the pad (asynchronous).
- sda_oe  out  1  1 pulls SDA low; 0 releases it (pad is tristate-to-0).
- reg_addr  out  8  register pointer; drives the register file address.
- reg_wdata  out  8  byte received from the bus.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read strobe; reg_rdata must be valid on the next clk.
- reg_rdata  in  8  read data from the register file.
- busy  out  1  high from address match until STOP, repeated START or NACK.

Behaviour:
- Reset values: sda_oe=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, state=IDLE.
- Reset mid-transfer releases SDA on the next clk edge.
- Input synchronisation:
  - scl_in and sda_in each pass through a 2-FF synchroniser, then a 1-FF history register for edge detection.
  - Events are 3 clk after the pad edge.
- START: SDA falls while SCL is high.
- STOP: SDA rises while SCL is high.
- Bit timing:
  - Bits are sampled on the detected SCL rising edge.
  - sda_oe changes only on the detected SCL falling edge.
- States:
  - IDLE
  - ADDR: shift 8 bits MSB first.
  - ADDR_ACK
  - PTR: write; first byte is the register pointer.
  - PTR_ACK
  - WDATA
  - WDATA_ACK
  - RDATA: drive 8 bits.
  - RACK: sample the host's ACK.
  - IGNORE
- START or repeated START from any state:
  - Enter ADDR, clear the bit counter, release SDA.
  - reg_addr is kept, so a read after a pointer write works.
- STOP from any state: enter IDLE, sda_oe=0, busy=0.
- START/STOP win over any SCL edge detected in the same cycle.
- ADDR, after the 8th rising edge:
  - If byte[7:1]==DEVICE_ADDR: assert sda_oe on the next SCL fall, set busy, go to ADDR_ACK.
  - Otherwise go to IGNORE and never drive SDA. General call (0x00) is not acknowledged.
- ADDR_ACK, on the SCL fall ending the ACK bit:
  - R/W=0: release SDA, go to PTR.
  - R/W=1: pulse reg_re; the next cycle latch reg_rdata into the tx shifter; go to RDATA and drive its MSB (sda_oe = ~bit) on the same fall.
- PTR, after 8 bits:
  - reg_addr <= byte, ACK, then go to WDATA.
- WDATA, after 8 bits:
  - reg_wdata <= byte, reg_we=1 for one cycle with the current reg_addr.
  - The cycle after reg_we: reg_addr <= reg_addr+1 (mod 256, so 0xFF wraps to 0x00). Then ACK.
  - Every write byte is acknowledged; there is no full condition.
- RDATA: after the 8th bit's SCL fall, release SDA and go to RACK.
- RACK, on the 9th rising edge:
  - reg_addr <= reg_addr+1 (mod 256) for either ACK or NACK.
  - SDA=0 (ACK): pulse reg_re, reload the shifter, go to RDATA.
  - SDA=1 (NACK): go to IGNORE, busy=0.
- IGNORE: wait for START or STOP.
- Pulse rules: reg_we and reg_re are never both high; each is at most one cycle per byte.
- Read-first after reset: a read with no pointer write starts at reg_addr=0x00.

Decomposition:
- Package i2c_pkg holds:
  - the state enum;
  - the constant BITS_PER_BYTE=8;
  - the START/STOP event encoding.
- The package is shared with i2c_controller.
- One sub-module, i2c_bus_sync, holds:
  - the 2-FF synchronisers and history FFs for SCL/SDA;
  - outputs scl, sda, scl_rise, scl_fall, start_det, stop_det.
- i2c_bus_sync is reusable by the controller's arbitration logic.

Test Plan:
- Write 0x6B then 0x00 to addr 0x68 (frame 0xD0, 0x6B, 0x00, STOP):
  - Three ACKs (SDA low on the 9th SCL).
  - Exactly one reg_we with reg_addr=0x6B, reg_wdata=0x00.
  - reg_addr=0x6C afterwards; busy falls at STOP.
- Frame 0xA0 (addr 0x50):
  - sda_oe stays 0 for the whole transfer.
  - No reg_we or reg_re; busy stays 0.
- Burst read:
  - Frame 0xD0, 0x3B, repeated START, 0xD1, then 3 bytes with ACK, ACK, NACK. Register model returns rdata = addr^0xA5.
  - Bus bytes are 0x9E, 0x99, 0x98.
  - Three reg_re pulses; reg_addr=0x3E at the end; SDA released after the NACK.
- Pointer wrap: pointer 0xFF, write 0x11, 0x22.
  - reg_we at 0xFF/0x11 then 0x00/0x22.
  - reg_addr=0x01.
- STOP injected after 4 bits of a write data byte:
  - No reg_we; state IDLE; sda_oe=0.
  - A following valid frame is ACKed normally.
- reset asserted while driving a 0 bit in RDATA:
  - sda_oe=0 on the next clk; reg_addr=0; busy=0.
  - The next 0xD1 read returns the byte from address 0x00.
